bit_synchronizers_filtered: RTL

Multi-channel clock-domain-crossing synchroniser for asynchronous level inputs such as buttons, switches and external status pins. Each channel has a configurable-depth flip-flop chain, a per-channel stability (glitch) filter, and registered rise/fall event pulses. It replaces the plain per-bit synchroniser array wherever the consuming logic needs clean, debounced levels or single-cycle edge events in the `clk_in` domain.

---
 rtl/bit_synchronizers_filtered.sv | 86 ++++++++
 1 files changed

// File: rtl/bit_synchronizers_filtered.sv
// Per-channel CDC sync chain, stability filter and registered rise/fall event pulses.
// Latency: STAGES + FILTER_CYCLES edges from the edge preceding an input change. There is no backpressure.
module bit_synchronizers_filtered #(
    parameter int               WIDTH         = 1,
    parameter int               STAGES        = 2,
    parameter int               FILTER_CYCLES = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] bits_in,
    output logic [WIDTH-1:0] bits_out,
    output logic [WIDTH-1:0] rise_out,
    output logic [WIDTH-1:0] fall_out,
    output logic             change_out
);

    localparam int            CW      = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

    logic [WIDTH-1:0] r_sync [STAGES];
    logic [CW-1:0]    r_cnt [WIDTH];
    logic [CW-1:0]    w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_accept;
    logic [WIDTH-1:0] r_bits;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_change;

    // Plain flop chain: nothing may sit between stages or metastability settling time is lost.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= RESET_VALUE;
            end
        end else begin
            r_sync[0] <= bits_in;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_s = r_sync[STAGES-1];

    always_comb begin
        w_accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = '0;
            if (w_s[i] != r_bits[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_accept[i] = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
            r_bits   <= RESET_VALUE;
            r_rise   <= '0;
            r_fall   <= '0;
            r_change <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_bits   <= (r_bits & ~w_accept) | (w_s & w_accept);
            r_rise   <= w_accept & w_s;
            r_fall   <= w_accept & ~w_s;
            r_change <= |w_accept;
        end
    end

    assign bits_out   = r_bits;
    assign rise_out   = r_rise;
    assign fall_out   = r_fall;
    assign change_out = r_change;

endmodule
